// File: rtl/uart_tx_buf.sv
// uart_tx_buf: FIFO-buffered LSB-first UART transmitter, 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined
module uart_tx_buf #(
    parameter int BPS     = 9600,
    parameter int CLK_FRE = 200_000_000,
    parameter int DEPTH   = 16
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic                         uart_txd,
    output logic                         tx_busy,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int BAUD_CNT = CLK_FRE / BPS;
    localparam int BW = $clog2(BAUD_CNT);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP  = 3'd4;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [2:0]    state, bit_cnt;
    logic [BW-1:0] baud;
    logic [7:0]    shift;
    logic          baud_end, push, pop;
`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    assign tx_ready = fifo_count != CW'(DEPTH);
    assign tx_busy  = state != IDLE;
    assign baud_end = baud == BAUD_LAST;
    assign push     = tx_valid && tx_ready;
    assign pop      = fifo_count != '0 && (state == IDLE || (state == STOP && baud_end));

    always_ff @(posedge sys_clk)
        if (push) mem[wptr] <= tx_data;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            state      <= IDLE;
            bit_cnt    <= '0;
            baud       <= '0;
            shift      <= '0;
            uart_txd   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            if (pop) begin
                shift    <= mem[rptr];
`ifdef UART_TX_PARITY_EN
                par      <= ^mem[rptr];
`endif
                state    <= START;
                baud     <= '0;
                uart_txd <= 1'b0;
            end else if (state == IDLE) begin
                baud     <= '0;
                uart_txd <= 1'b1;
            end else if (!baud_end) begin
                baud <= baud + BW'(1);
            end else begin
                baud <= '0;
                case (state)
                    START: begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        uart_txd <= shift[0];
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= par;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            shift    <= shift >> 1;
                            bit_cnt  <= bit_cnt + 3'd1;
                            uart_txd <= shift[1];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                    end
`endif
                    default: begin
                        state    <= IDLE;
                        uart_txd <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
